// File: rtl/ota_trim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ota_trim_sequencer
// Purpose  : Power-up and offset-calibration sequencer for the OTA macro.
//            Brings up bias, enables the OTA with its inputs shorted, then
//            runs a successive-approximation search on the offset-trim DAC
//            code using the (synchronised) OTA comparator output. The final
//            code is held on trim_o with trim_valid_o, announced by done_o.
// Ports    : clk          system clock
//            rst          asynchronous reset, active-high
//            start_i      level request to (re)calibrate, seen in IDLE/RUN
//            cmp_in_i     asynchronous comparator, 1 = trim code too high
//            bias_en_o    bias generator enable
//            ota_en_o     OTA core enable
//            short_en_o   input-short switch enable
//            trim_o       offset-trim DAC code (registered)
//            busy_o       high from BIAS through the last SAR step
//            done_o       one-cycle completion pulse
//            trim_valid_o trim_o holds a completed result
// Revision : 1.0 - initial release
// ============================================================================
module ota_trim_sequencer #(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cmp_in_i,
  output logic              bias_en_o,
  output logic              ota_en_o,
  output logic              short_en_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              trim_valid_o
);

  localparam int                IDX_W         = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [CNT_W-1:0]  C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0]  C_IDX_MSB     = IDX_W'(TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_SHORT = 3'd2,
    S_SAR   = 3'd3,
    S_DONE  = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic                cmp_meta_q;
  logic                cmp_s_q;
  logic                settle_last;

  // Two-flop synchroniser: the comparator is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_in_i;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      trim_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      trim_q  <= trim_d;
    end
  end

  assign settle_last = (cnt_q == C_SETTLE_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    idx_d        = idx_q;
    trim_d       = trim_q;
    bias_en_o    = 1'b0;
    ota_en_o     = 1'b0;
    short_en_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    trim_valid_o = 1'b0;

    // Every wait state restarts its counter on entry; wrapping to zero on
    // the exit edge covers SAR re-entering itself for the next bit.
    if (state_q == S_BIAS || state_q == S_SHORT || state_q == S_SAR) begin
      cnt_d = settle_last ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_BIAS;
          trim_d  = '0;
        end
      end

      S_BIAS: begin
        bias_en_o = 1'b1;
        busy_o    = 1'b1;
        if (settle_last) begin
          state_d = S_SHORT;
        end
      end

      S_SHORT: begin
        bias_en_o  = 1'b1;
        ota_en_o   = 1'b1;
        short_en_o = 1'b1;
        busy_o     = 1'b1;
        if (settle_last) begin
          // Trial value for the MSB is applied as SAR is entered.
          state_d             = S_SAR;
          idx_d               = C_IDX_MSB;
          trim_d              = '0;
          trim_d[TRIM_W-1]    = 1'b1;
        end
      end

      S_SAR: begin
        bias_en_o  = 1'b1;
        ota_en_o   = 1'b1;
        short_en_o = 1'b1;
        busy_o     = 1'b1;
        if (settle_last) begin
          // Comparator high means the trial code overshoots: drop the bit.
          if (cmp_s_q) begin
            trim_d[idx_q] = 1'b0;
          end
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d                 = idx_q - 1'b1;
            trim_d[idx_q - 1'b1]  = 1'b1;
          end
        end
      end

      S_DONE: begin
        bias_en_o    = 1'b1;
        ota_en_o     = 1'b1;
        done_o       = 1'b1;
        trim_valid_o = 1'b1;
        state_d      = S_RUN;
      end

      S_RUN: begin
        bias_en_o    = 1'b1;
        ota_en_o     = 1'b1;
        trim_valid_o = 1'b1;
        if (start_i) begin
          state_d = S_BIAS;
          trim_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        trim_d  = '0;
      end
    endcase
  end

  assign trim_o = trim_q;

endmodule
`default_nettype wire

// File: tb/tb_ota_trim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ota_trim_sequencer
// Purpose  : Self-checking bench for ota_trim_sequencer. Two instances: the
//            default configuration and a small one (TRIM_W=4, SETTLE_CYC=4).
//            A threshold comparator model closes the loop around trim_o.
//            Expected results go into a scoreboard queue when a calibration
//            is started and are popped when done_o pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ota_trim_sequencer;

  localparam int A_W = 6;
  localparam int A_S = 16;
  localparam int B_W = 4;
  localparam int B_S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           start_a, start_b;
  logic           cmp_a, cmp_b;
  logic           bias_a, ota_a, short_a, busy_a, done_a, valid_a;
  logic           bias_b, ota_b, short_b, busy_b, done_b, valid_b;
  logic [A_W-1:0] trim_a;
  logic [B_W-1:0] trim_b;
  int             thr_a, thr_b;
  logic           inv_b;

  // Comparator model: output high when the trim code reaches the threshold.
  // On instance B the output is inverted during the last two cycles of each
  // SAR step, which only a correctly synchronised sample point ignores.
  assign cmp_a = (int'(trim_a) >= thr_a);
  assign cmp_b = (int'(trim_b) >= thr_b) ^ inv_b;

  ota_trim_sequencer #(.TRIM_W(A_W), .SETTLE_CYC(A_S), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .cmp_in_i(cmp_a),
    .bias_en_o(bias_a), .ota_en_o(ota_a), .short_en_o(short_a),
    .trim_o(trim_a), .busy_o(busy_a), .done_o(done_a), .trim_valid_o(valid_a)
  );

  ota_trim_sequencer #(.TRIM_W(B_W), .SETTLE_CYC(B_S), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .cmp_in_i(cmp_b),
    .bias_en_o(bias_b), .ota_en_o(ota_b), .short_en_o(short_b),
    .trim_o(trim_b), .busy_o(busy_b), .done_o(done_b), .trim_valid_o(valid_b)
  );

  typedef struct {
    int trim;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] mk_flags(input bit bias, input bit ota, input bit shrt,
                                           input bit busy, input bit done, input bit valid);
    return {26'd0, bias, ota, shrt, busy, done, valid};
  endfunction

  function automatic logic [31:0] obs_flags(input bit b);
    return b ? {26'd0, bias_b, ota_b, short_b, busy_b, done_b, valid_b}
             : {26'd0, bias_a, ota_a, short_a, busy_a, done_a, valid_a};
  endfunction

  function automatic logic [31:0] obs_trim(input bit b);
    return b ? 32'(trim_b) : 32'(trim_a);
  endfunction

  function automatic logic obs_done(input bit b);
    return b ? done_b : done_a;
  endfunction

  function automatic logic obs_busy(input bit b);
    return b ? busy_b : busy_a;
  endfunction

  // Largest code whose comparator output is still low.
  function automatic int exp_trim(input int thr, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (thr <= 0) return 0;
    if (thr - 1 > mx) return mx;
    return thr - 1;
  endfunction

  task automatic drive_start(input bit b, input logic v);
    if (b) start_b = v;
    else   start_a = v;
  endtask

  // One full calibration. Called at a negedge; returns at a negedge.
  task automatic run_cal(input bit b, input int thr, input bit poke);
    exp_t e, got;
    int   w, s, cyc, busy_cnt, q, extra;
    bit   seen;
    w = b ? B_W : A_W;
    s = b ? B_S : A_S;
    if (b) thr_b = thr;
    else   thr_a = thr;
    e.trim = exp_trim(thr, w);
    e.busy = (2 + w) * s;
    sb.push_back(e);

    drive_start(b, 1'b1);
    @(negedge clk);
    drive_start(b, 1'b0);

    cyc = 1; busy_cnt = 0; seen = 0;
    while (!seen && cyc <= e.busy + 40) begin
      if (cyc == 1) begin
        check_val("bias_phase_flags", obs_flags(b), mk_flags(1, 0, 0, 1, 0, 0));
        check_val("bias_phase_trim", obs_trim(b), 0);
      end
      if (cyc == s + 1) begin
        check_val("short_phase_flags", obs_flags(b), mk_flags(1, 1, 1, 1, 0, 0));
        check_val("short_phase_trim", obs_trim(b), 0);
      end
      if (cyc == 2 * s + 1) begin
        check_val("sar_msb_trim", obs_trim(b), 32'(1 << (w - 1)));
      end
      if (obs_done(b) === 1'b1) begin
        seen = 1;
      end else begin
        if (obs_busy(b) === 1'b1) busy_cnt++;
        q = cyc - 2 * s - 1;
        inv_b = b && (q >= 0) && (q < w * s) && ((q % s) >= s - 2);
        drive_start(b, poke && (busy_cnt == 5 || busy_cnt == 100));
        @(negedge clk);
        cyc++;
      end
    end
    inv_b = 1'b0;
    drive_start(b, 1'b0);

    got = sb.pop_front();
    check_val("done_seen", 32'(seen), 1);
    check_val("result_trim", obs_trim(b), 32'(got.trim));
    check_val("done_cycle", 32'(cyc), 32'(got.busy + 1));
    check_val("busy_cycles", 32'(busy_cnt), 32'(got.busy));
    check_val("done_flags", obs_flags(b), mk_flags(1, 1, 0, 0, 1, 1));

    @(negedge clk);
    check_val("run_flags", obs_flags(b), mk_flags(1, 1, 0, 0, 0, 1));
    check_val("run_trim_held", obs_trim(b), 32'(got.trim));
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (obs_done(b) !== 1'b0) extra++;
    end
    check_val("no_extra_done", 32'(extra), 0);
    check_val("run_trim_still", obs_trim(b), 32'(got.trim));
  endtask

  // Start a calibration on instance A and reset it in the middle of the
  // SAR step that trials bit 3.
  task automatic reset_mid_sar();
    int bad;
    thr_a = 37;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4 * A_S + 4) @(negedge clk);
    check_val("mid_sar_busy", 32'(busy_a), 1);
    check_val("mid_sar_partial", 32'(trim_a), 40);
    rst = 1'b1;
    #1;
    check_val("async_rst_flags", obs_flags(0), 0);
    check_val("async_rst_trim", obs_trim(0), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (4 * A_S) begin
      @(negedge clk);
      if (obs_flags(0) !== 32'd0 || obs_trim(0) !== 32'd0) bad++;
    end
    check_val("post_rst_idle", 32'(bad), 0);
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    thr_a   = 0;
    thr_b   = 0;
    inv_b   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_flags_a", obs_flags(0), 0);
    check_val("reset_trim_a", obs_trim(0), 0);
    check_val("reset_flags_b", obs_flags(1), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_flags_a", obs_flags(0), 0);

    run_cal(0, 37, 1'b0);                    // nominal offset
    check_val("run_before_recal", obs_trim(0), 36);
    run_cal(0, 37, 1'b1);                    // recalibrate from RUN, start pokes ignored
    run_cal(0, 0, 1'b0);                     // comparator stuck high
    run_cal(0, 64, 1'b0);                    // comparator stuck low
    reset_mid_sar();
    run_cal(0, 22, 1'b0);                    // from IDLE after reset
    run_cal(1, 9, 1'b0);                     // small configuration
    run_cal(1, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
